// File: rtl/bcd_convert_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   the FSM state encoding and the double-dabble digit adjust constants.
// -----------------------------------------------------------------------------
package bcd_convert_seq_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 4;
    localparam int BCD_ADJ_ADD    = 3;

    // Encoding 2'd3 is unused and decodes back to IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational double-dabble digit correction: a BCD digit greater than 4
//   gets 3 added (mod 16) so that the following left shift carries correctly
//   into the next decimal digit.
// Ports
//   din   in   4   work digit before the shift
//   dout  out  4   adjusted digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_convert_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(BCD_ADJ_THRESH);
    localparam logic [BCD_DIGIT_W-1:0] ADD    = BCD_DIGIT_W'(BCD_ADJ_ADD);

    always_comb begin
        dout = din;
        if (din > THRESH) begin
            dout = din + ADD;
        end
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq
//   Multi-cycle binary-to-BCD converter using sequential double-dabble: one
//   operand bit is consumed per clock, so a conversion takes BIN_W cycles.
//   Valid/ready handshake on the operand side and on the result side.
// Parameters
//   BIN_W   width of the binary operand (= cycles per conversion)
//   DIGITS  number of 4-bit BCD digits produced
// Ports
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          operand offered
//   in_ready   out  1          converter idle and able to accept
//   in_bin     in   BIN_W      operand, sampled on accept
//   out_valid  out  1          result available
//   out_ready  in   1          consumer takes result
//   out_bcd    out  4*DIGITS   packed BCD, digit 0 (ones) in [3:0]
//   out_ovf    out  1          operand did not fit in DIGITS digits
//   busy       out  1          converting or holding a result
// -----------------------------------------------------------------------------
module bcd_convert_seq
    import bcd_convert_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_ovf,
    output logic                          busy
);

    localparam int WORK_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    sreg;
    logic [WORK_W-1:0]   work;
    logic                ovf_acc;
    logic [WORK_W-1:0]   out_bcd_r;
    logic                out_ovf_r;

    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_sh;
    logic                ovf_nx;
    logic                last_step;

    // All digits are corrected in parallel before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (work_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Operand MSB enters the ones digit; whatever leaves the top digit is
    // a carry into a digit we do not have, i.e. the value overflowed.
    assign work_sh   = {work_adj[WORK_W-2:0], sreg[BIN_W-1]};
    assign ovf_nx    = ovf_acc | work_adj[WORK_W-1];
    assign last_step = (cnt == CNT_W'(1));

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: begin
                state_nx = in_valid ? ST_CONVERT : ST_IDLE;
            end
            ST_CONVERT: begin
                state_nx = last_step ? ST_DONE : ST_CONVERT;
            end
            ST_DONE: begin
                state_nx = out_ready ? ST_IDLE : ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            work      <= '0;
            ovf_acc   <= 1'b0;
            out_bcd_r <= '0;
            out_ovf_r <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sreg    <= in_bin;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                    end
                end
                ST_CONVERT: begin
                    sreg    <= sreg << 1;
                    work    <= work_sh;
                    ovf_acc <= ovf_nx;
                    cnt     <= cnt - CNT_W'(1);
                    if (last_step) begin
                        out_bcd_r <= work_sh;
                        out_ovf_r <= ovf_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_CONVERT) || (state == ST_DONE);
    assign out_bcd   = out_bcd_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bcd_convert_seq.sv
module tb_bcd_convert_seq;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic        out_ovf;
    logic        busy;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_bin2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_bcd2;
    logic        out_ovf2;
    logic        busy2;

    int n_checks;
    int n_errors;

    bcd_convert_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    bcd_convert_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_bin    (in_bin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_bcd   (out_bcd2),
        .out_ovf   (out_ovf2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] ref3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on the 3-digit instance. tied=1 keeps out_ready high
    // throughout; otherwise out_ready is held low for 'stall' cycles after
    // out_valid before being released.
    task automatic conv(input logic [7:0] b, input int stall, input bit tied);
        int guard;
        int lat;
        logic [11:0] exp_bcd;
        exp_bcd = ref3(int'(b));
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        out_ready = tied;
        in_bin    = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_bin    = ~b;
        chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd8);
        chk("out_bcd", 32'(out_bcd), 32'(exp_bcd));
        chk("out_ovf", 32'(out_ovf), 32'd0);
        if (!tied) begin
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_bcd", 32'(out_bcd), 32'(exp_bcd));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        out_ready = tied;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("bcd_kept", 32'(out_bcd), 32'(exp_bcd));
    endtask

    task automatic conv2(input logic [7:0] b, input logic [7:0] exp_bcd, input logic exp_ovf);
        int lat;
        in_bin2   = b;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            tick();
            lat++;
        end
        chk("d2_latency", 32'(lat), 32'd8);
        chk("d2_out_bcd", 32'(out_bcd2), 32'(exp_bcd));
        chk("d2_out_ovf", 32'(out_ovf2), 32'(exp_ovf));
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk("d2_idle", 32'(in_ready2), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_bin     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_bin2    = '0;
        out_ready2 = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // 255 with single-cycle valid
        conv(8'd255, 0, 1'b0);

        // 0 then 99 with out_ready held high, including while idle
        out_ready = 1'b1;
        tick();
        chk("out_ready_idle_no_effect", 32'(in_ready), 32'd1);
        conv(8'd0, 0, 1'b1);
        conv(8'd99, 0, 1'b1);
        out_ready = 1'b0;

        // backpressure
        conv(8'd128, 5, 1'b0);

        // in_valid held with changing operand during CONVERT and DONE
        in_bin   = 8'd77;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 12 && !out_valid; i++) begin
            in_bin = in_bin + 8'd13;
            tick();
        end
        chk("held_valid_done", 32'(out_valid), 32'd1);
        chk("held_valid_bcd", 32'(out_bcd), 32'h077);
        tick();
        chk("held_valid_still_done", 32'(out_valid), 32'd1);
        chk("held_valid_bcd_stable", 32'(out_bcd), 32'h077);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("held_valid_no_extra_accept", 32'(busy), 32'd0);

        // reset during CONVERT
        in_bin   = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        conv(8'd42, 0, 1'b0);

        // two-digit instance: overflow and in-range
        conv2(8'd200, 8'h00, 1'b1);
        conv2(8'd57, 8'h57, 1'b0);
        conv2(8'd123, 8'h23, 1'b1);
        conv2(8'd99, 8'h99, 1'b0);

        // all operands with random consumer stalls
        for (int v = 0; v < 256; v++) begin
            conv(8'(v), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
